// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: handshake and ALU bus between two requesters, the shared
// ALU adder and the alu_arbiter.
//   req0_*/req1_* : operand request channels (valid/ready, operands a/b)
//   rsp0_*/rsp1_* : per-port response valid/ready
//   rsp_sum/rsp_c : shared result, qualified by rspN_valid
//   alu_ain/bin   : operands to the combinational ALU
//   alu_out/alu_c : ALU sum and carry
// Modports: slave = arbiter side, master = requesters + ALU side.
interface alu_arbiter_if #(
    parameter int WIDTH = 4
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             rsp0_valid;
    logic             rsp0_ready;
    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             rsp1_valid;
    logic             rsp1_ready;
    logic [WIDTH-1:0] rsp_sum;
    logic             rsp_c;
    logic [WIDTH-1:0] alu_ain;
    logic [WIDTH-1:0] alu_bin;
    logic [WIDTH-1:0] alu_out;
    logic             alu_c;

    modport slave (
        input  req0_valid, req0_a, req0_b, rsp0_ready,
        input  req1_valid, req1_a, req1_b, rsp1_ready,
        input  alu_out, alu_c,
        output req0_ready, rsp0_valid, req1_ready, rsp1_valid,
        output rsp_sum, rsp_c, alu_ain, alu_bin
    );

    modport master (
        output req0_valid, req0_a, req0_b, rsp0_ready,
        output req1_valid, req1_a, req1_b, rsp1_ready,
        output alu_out, alu_c,
        input  req0_ready, rsp0_valid, req1_ready, rsp1_valid,
        input  rsp_sum, rsp_c, alu_ain, alu_bin
    );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational adder between two requesters.
// Round-robin grant in IDLE, one EXEC cycle where the ALU is driven from
// registered operands and its result captured, then RESP until the owner
// takes the result.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : alu_arbiter_if.slave (request/response channels, ALU bus)
// Optional build macro ALU_ARB_STATS_EN adds 8-bit wrapping counters:
//   grant_cnt0, grant_cnt1 : accepts per port
//   contend_cnt            : IDLE cycles with both requests valid
module alu_arbiter #(
    parameter int WIDTH     = 4,
    parameter bit INIT_PRIO = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    alu_arbiter_if.slave      bus
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [7:0]        grant_cnt0,
    output logic [7:0]        grant_cnt1,
    output logic [7:0]        contend_cnt
`endif
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state_q, state_d;
    logic             prio_q, prio_d;       // port that wins a tie
    logic             owner_q, owner_d;     // port of the transaction in flight
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             c_q, c_d;
    logic             rsp0_valid_q, rsp0_valid_d;
    logic             rsp1_valid_q, rsp1_valid_d;
    logic             grant0, grant1;
    logic             owner_ready;

    // Grants only exist in IDLE and only for a valid port, so ready never
    // rises for an idle requester.
    always_comb begin
        grant0 = (state_q == IDLE) && bus.req0_valid && (!bus.req1_valid || !prio_q);
        grant1 = (state_q == IDLE) && bus.req1_valid && (!bus.req0_valid ||  prio_q);
    end

    assign owner_ready = owner_q ? bus.rsp1_ready : bus.rsp0_ready;

    always_comb begin
        state_d      = state_q;
        prio_d       = prio_q;
        owner_d      = owner_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        sum_d        = sum_q;
        c_d          = c_q;
        rsp0_valid_d = rsp0_valid_q;
        rsp1_valid_d = rsp1_valid_q;
        case (state_q)
            IDLE: begin
                if (grant0 || grant1) begin
                    op_a_d  = grant1 ? bus.req1_a : bus.req0_a;
                    op_b_d  = grant1 ? bus.req1_b : bus.req0_b;
                    owner_d = grant1;
                    prio_d  = !grant1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                sum_d        = bus.alu_out;
                c_d          = bus.alu_c;
                rsp0_valid_d = !owner_q;
                rsp1_valid_d =  owner_q;
                state_d      = RESP;
            end
            RESP: begin
                // rsp_ready from the non-owner is ignored here.
                if (owner_ready) begin
                    rsp0_valid_d = 1'b0;
                    rsp1_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            prio_q       <= INIT_PRIO;
            owner_q      <= 1'b0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            sum_q        <= '0;
            c_q          <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            prio_q       <= prio_d;
            owner_q      <= owner_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            sum_q        <= sum_d;
            c_q          <= c_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
        end
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.rsp0_valid = rsp0_valid_q;
    assign bus.rsp1_valid = rsp1_valid_q;
    assign bus.rsp_sum    = sum_q;
    assign bus.rsp_c      = c_q;
    assign bus.alu_ain    = op_a_q;
    assign bus.alu_bin    = op_b_q;

`ifdef ALU_ARB_STATS_EN
    logic [7:0] grant_cnt0_q, grant_cnt0_d;
    logic [7:0] grant_cnt1_q, grant_cnt1_d;
    logic [7:0] contend_cnt_q, contend_cnt_d;

    always_comb begin
        grant_cnt0_d  = grant_cnt0_q + 8'(grant0);
        grant_cnt1_d  = grant_cnt1_q + 8'(grant1);
        contend_cnt_d = contend_cnt_q
                      + 8'((state_q == IDLE) && bus.req0_valid && bus.req1_valid);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant_cnt0_q  <= '0;
            grant_cnt1_q  <= '0;
            contend_cnt_q <= '0;
        end else begin
            grant_cnt0_q  <= grant_cnt0_d;
            grant_cnt1_q  <= grant_cnt1_d;
            contend_cnt_q <= contend_cnt_d;
        end
    end

    assign grant_cnt0  = grant_cnt0_q;
    assign grant_cnt1  = grant_cnt1_q;
    assign contend_cnt = contend_cnt_q;
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed cases with hand-computed values, then
// random traffic, all also checked every cycle against a transaction-level
// model of the arbiter.
module tb_alu_arbiter;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    alu_arbiter_if #(.WIDTH(W)) bus ();

`ifdef ALU_ARB_STATS_EN
    logic [7:0] grant_cnt0, grant_cnt1, contend_cnt;
`endif

    alu_arbiter #(.WIDTH(W), .INIT_PRIO(1'b0)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef ALU_ARB_STATS_EN
        ,
        .grant_cnt0(grant_cnt0),
        .grant_cnt1(grant_cnt1),
        .contend_cnt(contend_cnt)
`endif
    );

    // The shared adder.
    assign {bus.alu_c, bus.alu_out} = bus.alu_ain + bus.alu_bin;

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    bit         m_on = 1'b0;   // model tracking after first reset
    bit         m_busy;        // a transaction is in flight
    int         m_age;         // cycles since accept (capped at 1)
    int         m_owner;
    int         m_prio;        // port that wins a tie
    int         m_a, m_b, m_sum, m_c;
    logic [7:0] m_g0, m_g1, m_ct;

    always @(negedge clk) begin
        bit v0, v1, er0, er1, ev0, ev1;
        int s;
        v0  = bus.req0_valid;
        v1  = bus.req1_valid;
        er0 = !m_busy && v0 && (!v1 || m_prio == 0);
        er1 = !m_busy && v1 && (!v0 || m_prio == 1);
        ev0 = m_busy && m_age >= 1 && m_owner == 0;
        ev1 = m_busy && m_age >= 1 && m_owner == 1;
        if (m_on) begin
            check("m_ready0", bus.req0_ready, er0);
            check("m_ready1", bus.req1_ready, er1);
            check("m_rsp0_valid", bus.rsp0_valid, ev0);
            check("m_rsp1_valid", bus.rsp1_valid, ev1);
            check("m_alu_ain", bus.alu_ain, m_a);
            check("m_alu_bin", bus.alu_bin, m_b);
            if (ev0 || ev1) begin
                check("m_rsp_sum", bus.rsp_sum, m_sum);
                check("m_rsp_c", bus.rsp_c, m_c);
            end
`ifdef ALU_ARB_STATS_EN
            check("m_grant_cnt0", grant_cnt0, m_g0);
            check("m_grant_cnt1", grant_cnt1, m_g1);
            check("m_contend_cnt", contend_cnt, m_ct);
`endif
        end
        // Inputs are stable until after the next posedge, so this is the
        // step the DUT will take at that edge.
        if (rst) begin
            m_on = 1'b1; m_busy = 1'b0; m_age = 0; m_owner = 0; m_prio = 0;
            m_a = 0; m_b = 0; m_sum = 0; m_c = 0;
            m_g0 = '0; m_g1 = '0; m_ct = '0;
        end else if (m_on) begin
            if (!m_busy) begin
                if (v0 && v1) m_ct++;
                if (er0 || er1) begin
                    m_owner = er1 ? 1 : 0;
                    m_a     = er1 ? int'(bus.req1_a) : int'(bus.req0_a);
                    m_b     = er1 ? int'(bus.req1_b) : int'(bus.req0_b);
                    s       = m_a + m_b;
                    m_sum   = s % (1 << W);
                    m_c     = (s >= (1 << W)) ? 1 : 0;
                    m_prio  = 1 - m_owner;
                    m_busy  = 1'b1;
                    m_age   = 0;
                    if (er1) m_g1++; else m_g0++;
                end
            end else if (m_age == 0) begin
                m_age = 1;
            end else if ((m_owner == 0 && bus.rsp0_ready) || (m_owner == 1 && bus.rsp1_ready)) begin
                m_busy = 1'b0;
            end
        end
    end

    // ---------------- directed + random stimulus ----------------
    task automatic idle_inputs();
        bus.req0_valid = 0; bus.req1_valid = 0;
        bus.req0_a = '0; bus.req0_b = '0; bus.req1_a = '0; bus.req1_b = '0;
        bus.rsp0_ready = 0; bus.rsp1_ready = 0;
    endtask

    initial begin
        int grants[$];
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // reset state
        @(negedge clk);
        check("rst_ready0", bus.req0_ready, 0);
        check("rst_ready1", bus.req1_ready, 0);
        check("rst_rsp0_valid", bus.rsp0_valid, 0);
        check("rst_rsp1_valid", bus.rsp1_valid, 0);
        check("rst_alu_ain", bus.alu_ain, 0);
        check("rst_alu_bin", bus.alu_bin, 0);
        check("rst_sum", bus.rsp_sum, 0);
        check("rst_c", bus.rsp_c, 0);

        // single request 1+1 on port 0
        @(posedge clk); #1;
        bus.req0_valid = 1; bus.req0_a = 4'h1; bus.req0_b = 4'h1; bus.rsp0_ready = 1;
        @(negedge clk); check("single_ready0", bus.req0_ready, 1);
        @(posedge clk); #1 bus.req0_valid = 0;
        @(negedge clk); check("single_exec_valid", bus.rsp0_valid, 0);
        @(negedge clk);
        check("single_valid", bus.rsp0_valid, 1);
        check("single_sum", bus.rsp_sum, 2);
        check("single_c", bus.rsp_c, 0);
        @(negedge clk); check("single_done", bus.rsp0_valid, 0);

        // overflow F+F on port 1
        @(posedge clk); #1;
        bus.req1_valid = 1; bus.req1_a = 4'hF; bus.req1_b = 4'hF; bus.rsp1_ready = 1;
        @(negedge clk); check("ovf_ready1", bus.req1_ready, 1);
        @(posedge clk); #1 bus.req1_valid = 0;
        @(negedge clk); check("ovf_exec_rsp0", bus.rsp0_valid, 0);
        @(negedge clk);
        check("ovf_valid1", bus.rsp1_valid, 1);
        check("ovf_rsp0", bus.rsp0_valid, 0);
        check("ovf_sum", bus.rsp_sum, 14);
        check("ovf_c", bus.rsp_c, 1);
        @(negedge clk); check("ovf_done", bus.rsp1_valid, 0);

        // contention: grants must alternate starting with port 0
        @(posedge clk); #1;
        bus.req0_valid = 1; bus.req0_a = 4'h0; bus.req0_b = 4'h1;
        bus.req1_valid = 1; bus.req1_a = 4'h1; bus.req1_b = 4'h0;
        bus.rsp0_ready = 1; bus.rsp1_ready = 1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.req0_ready) grants.push_back(0);
            if (bus.req1_ready) grants.push_back(1);
        end
        @(posedge clk); #1 idle_inputs();
        check("cont_ngrants", grants.size(), 4);
        for (int i = 0; i < grants.size() && i < 4; i++)
            check("cont_grant", grants[i], i % 2);

        // backpressure on port 0 with port 1 pending
        @(posedge clk); #1;
        bus.req0_valid = 1; bus.req0_a = 4'h3; bus.req0_b = 4'h4; bus.rsp0_ready = 0;
        @(negedge clk); check("bp_ready0", bus.req0_ready, 1);
        @(posedge clk); #1;
        bus.req0_valid = 0;
        bus.req1_valid = 1; bus.req1_a = 4'h2; bus.req1_b = 4'h2; bus.rsp1_ready = 1;
        @(negedge clk); check("bp_exec_ready1", bus.req1_ready, 0);
        @(negedge clk);
        check("bp_valid0", bus.rsp0_valid, 1);
        check("bp_sum", bus.rsp_sum, 7);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold_valid", bus.rsp0_valid, 1);
            check("bp_hold_sum", bus.rsp_sum, 7);
            check("bp_hold_ready1", bus.req1_ready, 0);
        end
        @(posedge clk); #1 bus.rsp0_ready = 1;
        @(negedge clk);
        check("bp_rel_ready1", bus.req1_ready, 0);
        check("bp_rel_valid0", bus.rsp0_valid, 1);
        @(negedge clk);
        check("bp_after_ready1", bus.req1_ready, 1);
        check("bp_after_valid0", bus.rsp0_valid, 0);
        @(posedge clk); #1 bus.req1_valid = 0;
        repeat (3) @(posedge clk);

        // reset during EXEC aborts the transaction and restores priority
        #1;
        bus.req0_valid = 1; bus.req0_a = 4'h5; bus.req0_b = 4'h5; bus.rsp0_ready = 1;
        @(negedge clk); check("rx_ready0", bus.req0_ready, 1);
        @(posedge clk); #1 bus.req0_valid = 0; rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("rx_alu_ain", bus.alu_ain, 0);
`ifdef ALU_ARB_STATS_EN
        check("rx_grant_cnt0", grant_cnt0, 0);
        check("rx_grant_cnt1", grant_cnt1, 0);
        check("rx_contend_cnt", contend_cnt, 0);
`endif
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            check("rx_rsp0_valid", bus.rsp0_valid, 0);
            check("rx_rsp1_valid", bus.rsp1_valid, 0);
        end
        @(posedge clk); #1 bus.req0_valid = 1; bus.req1_valid = 1;
        @(negedge clk);
        check("rx_prio_ready0", bus.req0_ready, 1);
        check("rx_prio_ready1", bus.req1_ready, 0);
        @(posedge clk); #1 idle_inputs(); bus.rsp0_ready = 1;
        repeat (3) @(posedge clk);

        // random traffic, checked by the model
        for (int i = 0; i < 600; i++) begin
            #1;
            bus.req0_valid = ($urandom_range(0, 3) != 0);
            bus.req1_valid = ($urandom_range(0, 3) != 0);
            bus.req0_a = W'($urandom); bus.req0_b = W'($urandom);
            bus.req1_a = W'($urandom); bus.req1_b = W'($urandom);
            bus.rsp0_ready = ($urandom_range(0, 2) != 0);
            bus.rsp1_ready = ($urandom_range(0, 2) != 0);
            rst = ($urandom_range(0, 99) == 0);
            @(posedge clk);
        end
        #1 idle_inputs(); rst = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
